// File: rtl/cpu_out_port.sv
// cpu_out_port: CPU write-strobe FIFO drained over valid/ready, with full/count/sticky overflow status.
// Define CPU_OUT_PORT_PARITY_EN to store an even-parity bit per word and present it on out_parity.
module cpu_out_port #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic              full,
   output logic [PTR_W:0]    count,
   output logic              overflow,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
`ifdef CPU_OUT_PORT_PARITY_EN
   output logic              out_parity,
`endif
   input  logic              out_ready
);
`ifdef CPU_OUT_PORT_PARITY_EN
   localparam int W = DATA_W + 1;
   logic [W-1:0] wword;
   assign wword = {^wdata, wdata};
`else
   localparam int W = DATA_W;
   logic [W-1:0] wword;
   assign wword = wdata;
`endif
   logic [W-1:0]       mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic               push, pop;
   logic [W-1:0]       head;
   // Status flags come only from the registered count, never from we/out_ready.
   assign full      = count == (PTR_W+1)'(DEPTH);
   assign out_valid = count != '0;
   assign pop       = out_valid & out_ready;
   assign push      = we & (~full | pop);
   assign head      = out_valid ? mem[rd_ptr] : '0;
   assign out_data  = head[DATA_W-1:0];
`ifdef CPU_OUT_PORT_PARITY_EN
   assign out_parity = head[DATA_W];
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         if (we & ~push) overflow <= 1'b1;
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wword;
endmodule

// File: tb/tb_cpu_out_port.sv
// tb_cpu_out_port: directed and random checks of cpu_out_port against a queue-based model.
// Covers parity output when CPU_OUT_PORT_PARITY_EN is defined.
module tb_cpu_out_port;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              we = 1'b0;
   logic [DATA_W-1:0] wdata = '0;
   logic              out_ready = 1'b0;
   logic              full, overflow, out_valid;
   logic [PTR_W:0]    count;
   logic [DATA_W-1:0] out_data;
`ifdef CPU_OUT_PORT_PARITY_EN
   logic              out_parity;
`endif

   cpu_out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .reset(reset), .we(we), .wdata(wdata), .full(full), .count(count),
      .overflow(overflow), .out_valid(out_valid), .out_data(out_data),
`ifdef CPU_OUT_PORT_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] q[$];
   logic              m_ovf = 1'b0;
   int                errors = 0;
   int                checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [DATA_W-1:0] h;
      h = q.size() > 0 ? q[0] : '0;
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
      chk({tag, ".data"}, 32'(out_data), 32'(h));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef CPU_OUT_PORT_PARITY_EN
      chk({tag, ".par"}, 32'(out_parity), 32'(q.size() > 0 ? ^h : 1'b0));
`endif
   endtask

   // Called just after a falling edge: drive, model one rising edge, check at next falling edge.
   task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d, input logic r);
      bit do_pop, do_push;
      we = w; wdata = d; out_ready = r;
      do_pop  = q.size() > 0 && r;
      do_push = w && (q.size() < DEPTH || do_pop);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (w && !do_push) m_ovf = 1'b1;
      @(negedge clk);
      chk_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      #1 chk_all(tag);
      #1 reset = 1'b1;
      we = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk_all({tag, ".post"});
   endtask

   initial begin
      #2 chk_all("rst");
      #8 reset = 1'b1;
      for (int i = 0; i < 5; i++) step("idle", 1'b0, '0, 1'b0);

      step("single.w", 1'b1, 8'd5, 1'b0);
      step("single.r", 1'b0, '0, 1'b1);

      for (int i = 1; i <= 4; i++) step("fill", 1'b1, DATA_W'(i), 1'b0);
      chk("fill.full", 32'(full), 32'd1);
      step("ovf", 1'b1, 8'd9, 1'b0);
      chk("ovf.set", 32'(overflow), 32'd1);
      for (int i = 0; i < 5; i++) step("drain", 1'b0, '0, 1'b1);
      chk("drain.ovf_sticky", 32'(overflow), 32'd1);

      async_reset("rst1");
      for (int i = 1; i <= 4; i++) step("refill", 1'b1, DATA_W'(i), 1'b0);
      step("simul", 1'b1, 8'd7, 1'b1);
      chk("simul.count", 32'(count), 32'd4);
      chk("simul.head", 32'(out_data), 32'd2);
      for (int i = 0; i < 4; i++) step("simul.drain", 1'b0, '0, 1'b1);

      for (int i = 0; i < 10; i++) begin
         step("wrap.w", 1'b1, DATA_W'(i), 1'b0);
         chk("wrap.data", 32'(out_data), i);
         chk("wrap.le1", 32'(count <= 1), 32'd1);
         step("wrap.r", 1'b0, '0, 1'b1);
      end

      for (int i = 0; i < 3; i++) step("burst", 1'b1, DATA_W'(8'h30 + i), 1'b0);
      chk("burst.count", 32'(count), 32'd3);
      async_reset("rst_mid");
      step("post42", 1'b1, 8'd42, 1'b0);
      chk("post42.data", 32'(out_data), 32'd42);
`ifdef CPU_OUT_PORT_PARITY_EN
      chk("post42.par", 32'(out_parity), 32'd1);
`endif
      step("post42.r", 1'b0, '0, 1'b1);

      for (int i = 0; i < 300; i++)
         step("rand", $urandom_range(0, 99) < 60, DATA_W'($urandom), $urandom_range(0, 99) < 45);
      async_reset("rst_end");
      for (int i = 0; i < 100; i++)
         step("rand2", $urandom_range(0, 99) < 40, DATA_W'($urandom), $urandom_range(0, 99) < 60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_out_port.md
Name: cpu_out_port

Overview:
- Output-port peripheral directly downstream of the single-cycle CPU.
- The CPU's output instruction raises a one-cycle write strobe. This block buffers each written word in a small FIFO and presents it to an external consumer over a valid/ready handshake.
- Decouples the one-instruction-per-cycle CPU from a slower consumer.
- Reports full, occupancy and a sticky overflow flag back to the CPU side.

Parameters:
- DATA_W, 8, width of CPU register / output word
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2
- PTR_W, 2, log2(DEPTH); must be kept consistent with DEPTH

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- we  in  1  CPU write strobe; one word per cycle where we=1
- wdata  in  DATA_W  word to enqueue, sampled on clk rising edge when we=1
- full  out  1  1 when occupancy == DEPTH
- count  out  PTR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set when a write is dropped
- out_valid  out  1  head word available to consumer
- out_data  out  DATA_W  head word; stable while out_valid=1 and out_ready=0
- out_ready  in  1  consumer accepts the head word this cycle

Behaviour:
- Reset (reset=0, async):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - full=0, out_valid=0, out_data=0.
  - Storage contents are don't-care.
- Definitions:
  - push = we & (~full | pop).
  - pop = out_valid & out_ready.
- Enqueue: on push, mem[wr_ptr]<=wdata and wr_ptr<=wr_ptr+1, wrapping modulo DEPTH.
- Dequeue: on pop, rd_ptr<=rd_ptr+1, wrapping modulo DEPTH.
- Occupancy:
  - count <= count + push - pop.
  - full and out_valid are derived from count after the same edge. They are never combinational from we or out_ready.
- out_data:
  - Equals mem[rd_ptr] whenever out_valid=1.
  - Is 0 when empty.
- Latency: a word written at edge k appears with out_valid=1 in the cycle after edge k. There is no empty-bypass.
- Ordering: strict FIFO; words leave in write order.
- Boundary conditions:
  - Empty with we=1 and out_ready=1: push only. The pop is ignored because out_valid=0, so count becomes 1.
  - Full with we=1 and pop=1: both occur. count stays DEPTH and the new word lands in the freed slot.
  - Full with we=1 and pop=0: the write is dropped. overflow<=1, and the pointers and count are unchanged.
  - overflow remains 1 until reset.
  - out_ready=1 while empty: no effect.
  - Pointer wrap: after DEPTH pushes and pops, the pointers return to 0 with no loss.
- Reset asserted mid-operation: the FIFO empties immediately. Outputs take their reset values asynchronously. The first clk edge after release is an ordinary cycle.
- The CPU side has no backpressure into the instruction stream. Software polls full/count; the block never stalls the CPU.

Optional Feature:
- Macro: CPU_OUT_PORT_PARITY_EN.
- Defined:
  - Each entry stores wdata plus an even-parity bit computed at write time (^wdata).
  - Extra output out_parity (1 bit) is present. It is valid with out_data and 0 when empty or in reset.
  - Storage width becomes DATA_W+1.
- Undefined: the out_parity port and the parity storage are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: hold reset=0 for 10 ns, release, no writes for 5 cycles -> count=0, full=0, out_valid=0, out_data=0, overflow=0 throughout.
- Single word: we=1, wdata=8'd5 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=5, count=1. Raise out_ready for one cycle -> out_valid=0, count=0.
- Fill, overflow and drain:
  - Write 1,2,3,4 on consecutive cycles with out_ready=0 -> full=1, count=4.
  - Write 9 -> dropped, overflow=1, count=4.
  - Set out_ready=1 -> out_data sequence 1,2,3,4, then out_valid=0. overflow stays 1.
- Simultaneous on full: FIFO holding 1,2,3,4, apply we=1 with wdata=7 and out_ready=1 in the same cycle -> count stays 4, overflow=0, drain order 2,3,4,7.
- Wrap-around: stream 10 words (values 0..9), writing and reading on alternate cycles -> all 10 received in order, count never exceeds 1, pointers wrap twice.
- Async reset mid-burst: with count=3, pull reset low between clock edges -> count, out_valid and full go to 0 before the next edge. After release, writing 8'd42 yields out_data=42. With CPU_OUT_PORT_PARITY_EN, also check out_parity=1 for 42 (8'b00101010).
